// File: rtl/klein_dec_key_sequencer.sv
// KLEIN-64 decryption key sequencer.
// Expands the master key into all NR+1 round keys, then hands them to the
// inverse-round controller newest-first over a valid/ready handshake.
module klein_dec_key_sequencer #(
  parameter int NR    = 12,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [63:0]      key,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [63:0]      round_key,
  output logic [IDX_W-1:0] round_idx,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_ISSUE  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_STEP = IDX_W'(NR);
  localparam logic [IDX_W-1:0] LAST_KEY  = IDX_W'(NR + 1);
  localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);

  // Cipher S-box (an involution, so it also serves the inverse rounds)
  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'h7;
      4'h1: sbox = 4'h4;
      4'h2: sbox = 4'hA;
      4'h3: sbox = 4'h9;
      4'h4: sbox = 4'h1;
      4'h5: sbox = 4'hF;
      4'h6: sbox = 4'hB;
      4'h7: sbox = 4'h0;
      4'h8: sbox = 4'hC;
      4'h9: sbox = 4'h3;
      4'hA: sbox = 4'h2;
      4'hB: sbox = 4'h6;
      4'hC: sbox = 4'h8;
      4'hD: sbox = 4'hE;
      4'hE: sbox = 4'hD;
      default: sbox = 4'h5;
    endcase
  endfunction

  state_t           r_state;
  logic [63:0]      r_buf [1:NR+1];
  logic [63:0]      r_cur;
  logic [IDX_W-1:0] r_i;
  logic             r_busy;
  logic             r_rk_valid;
  logic [63:0]      r_round_key;
  logic [IDX_W-1:0] r_round_idx;
  logic             r_done;

  logic             w_accept_start;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_ptr_dec;
  logic [7:0]       w_rc;
  logic [31:0]      w_a_rot;
  logic [31:0]      w_b_rot;
  logic [31:0]      w_a_new;
  logic [31:0]      w_b_mix;
  logic [15:0]      w_b_sub;
  logic [63:0]      w_next;

  // A start coinciding with the done pulse belongs to the finished sequence
  assign w_accept_start = (r_state == S_IDLE) && start && !r_done;
  assign w_wr_idx       = r_i + ONE;
  assign w_ptr_dec      = r_round_idx - ONE;
  assign w_rc           = 8'(r_i);

  // One forward schedule step: byte-rotate both halves, Feistel-like swap,
  // round constant into byte 2 of a, S-box on bytes 1 and 2 of b
  assign w_a_rot = {r_cur[55:32], r_cur[63:56]};
  assign w_b_rot = {r_cur[23:0],  r_cur[31:24]};
  assign w_a_new = w_b_rot ^ {16'h0000, w_rc, 8'h00};
  assign w_b_mix = w_a_rot ^ w_b_rot;

  for (genvar gi = 0; gi < 4; gi++) begin : g_sub
    assign w_b_sub[gi*4 +: 4] = sbox(w_b_mix[8 + gi*4 +: 4]);
  end

  assign w_next = {w_a_new, w_b_mix[31:24], w_b_sub, w_b_mix[7:0]};

  // Key buffer: master key on start, one expanded key per EXPAND cycle
  always_ff @(posedge clk) begin
    if (w_accept_start) begin
      r_buf[1] <= key;
    end else if (r_state == S_EXPAND) begin
      r_buf[w_wr_idx] <= w_next;
    end
  end

  // Control FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cur       <= '0;
      r_i         <= '0;
      r_busy      <= 1'b0;
      r_rk_valid  <= 1'b0;
      r_round_key <= '0;
      r_round_idx <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept_start) begin
            r_cur   <= key;
            r_i     <= ONE;
            r_busy  <= 1'b1;
            r_state <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          r_cur <= w_next;
          if (r_i == LAST_STEP) begin
            // Newest key goes straight to the output; the buffer copy is never read
            r_state     <= S_ISSUE;
            r_rk_valid  <= 1'b1;
            r_round_key <= w_next;
            r_round_idx <= LAST_KEY;
          end else begin
            r_i <= r_i + ONE;
          end
        end
        S_ISSUE: begin
          if (rk_ready) begin
            if (r_round_idx == ONE) begin
              r_rk_valid  <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_round_key <= '0;
              r_round_idx <= '0;
              r_state     <= S_IDLE;
            end else begin
              r_round_key <= r_buf[w_ptr_dec];
              r_round_idx <= w_ptr_dec;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign rk_valid  = r_rk_valid;
  assign round_key = r_round_key;
  assign round_idx = r_round_idx;
  assign done      = r_done;

endmodule

// File: tb/tb_klein_dec_key_sequencer.sv
// Bench for the KLEIN-64 decryption key sequencer: a scoreboard of expected
// keys is filled when a sequence is started and drained as keys are accepted.
module tb_klein_dec_key_sequencer;

  localparam int NR    = 12;
  localparam int IDX_W = 4;
  localparam logic [63:0] SBOX_TBL = 64'h74A91FB0C3268ED5;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [63:0]      key;
  logic             busy;
  logic             rk_valid;
  logic             rk_ready;
  logic [63:0]      round_key;
  logic [IDX_W-1:0] round_idx;
  logic             done;

  klein_dec_key_sequencer #(.NR(NR), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key       (key),
    .busy      (busy),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;
  int n_done   = 0;

  logic [IDX_W+63:0] sb [$];
  logic [IDX_W+63:0] sb_e;
  logic [63:0]       got [0:15];
  bit                exp_done = 1'b0;
  bit                hold_v   = 1'b0;
  logic [63:0]       hold_key;
  logic [IDX_W-1:0]  hold_idx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference models ----------------
  function automatic logic [3:0] sb4(input logic [3:0] x);
    logic [63:0] t;
    t = SBOX_TBL;
    return t[(15 - int'(x))*4 +: 4];
  endfunction

  function automatic logic [63:0] ks_step(input logic [63:0] k, input int i);
    logic [31:0] a, b, ar, br, an, bn;
    logic [7:0]  rc;
    a  = k[63:32];
    b  = k[31:0];
    ar = {a[23:0], a[31:24]};
    br = {b[23:0], b[31:24]};
    an = br;
    bn = ar ^ br;
    rc = 8'(i);
    an[15:8] = an[15:8] ^ rc;
    bn[23:20] = sb4(bn[23:20]);
    bn[19:16] = sb4(bn[19:16]);
    bn[15:12] = sb4(bn[15:12]);
    bn[11:8]  = sb4(bn[11:8]);
    return {an, bn};
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] b, input int m);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    case (m)
      9:       return x8 ^ b;
      11:      return x8 ^ x2 ^ b;
      13:      return x8 ^ x4 ^ b;
      default: return x8 ^ x4 ^ x2;
    endcase
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {gm(a0,14) ^ gm(a1,11) ^ gm(a2,13) ^ gm(a3,9),
            gm(a0,9)  ^ gm(a1,14) ^ gm(a2,11) ^ gm(a3,13),
            gm(a0,13) ^ gm(a1,9)  ^ gm(a2,14) ^ gm(a3,11),
            gm(a0,11) ^ gm(a1,13) ^ gm(a2,9)  ^ gm(a3,14)};
  endfunction

  // Inverse cipher driven by the keys the DUT actually issued
  function automatic logic [63:0] decrypt(input logic [63:0] c);
    logic [63:0] s;
    s = c ^ got[NR+1];
    for (int r = NR; r >= 1; r--) begin
      s = {inv_col(s[63:32]), inv_col(s[31:0])};
      s = {s[15:0], s[63:16]};
      for (int n = 0; n < 16; n++) s[n*4 +: 4] = sb4(s[n*4 +: 4]);
      s = s ^ got[r];
    end
    return s;
  endfunction

  task automatic push_exp(input logic [63:0] k);
    logic [63:0] ks [1:NR+1];
    ks[1] = k;
    for (int i = 1; i <= NR; i++) ks[i+1] = ks_step(ks[i], i);
    for (int i = NR + 1; i >= 1; i--) sb.push_back({IDX_W'(i), ks[i]});
  endtask

  // ---------------- monitor / scoreboard drain ----------------
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      exp_done = 1'b0;
      hold_v   = 1'b0;
    end else begin
      chk("done_pulse", 64'(done), 64'(exp_done));
      exp_done = 1'b0;
      if (done === 1'b1) n_done++;
      if (hold_v) begin
        chk("stall_valid", 64'(rk_valid), 64'd1);
        chk("stall_key", round_key, hold_key);
        chk("stall_idx", 64'(round_idx), 64'(hold_idx));
      end
      hold_v = 1'b0;
      if (rk_valid === 1'b1) begin
        if (rk_ready === 1'b1) begin
          n_acc++;
          got[round_idx] = round_key;
          n_checks++;
          assert (sb.size() != 0) else begin
            n_errors++;
            $error("FAIL unexpected_key: observed idx %0d key %h expected none", round_idx, round_key);
          end
          if (sb.size() != 0) begin
            sb_e = sb.pop_front();
            chk("key_idx", 64'(round_idx), 64'(sb_e[IDX_W+63:64]));
            chk("key_val", round_key, sb_e[63:0]);
          end
          if (round_idx == IDX_W'(1)) exp_done = 1'b1;
        end else begin
          hold_v   = 1'b1;
          hold_key = round_key;
          hold_idx = round_idx;
        end
      end
    end
  end

  // ---------------- one full sequence ----------------
  task automatic run(input logic [63:0] k, input bit rnd_ready, input bit hold_start,
                     output int lat, output int tot);
    int acc0, done0;
    acc0 = n_acc;
    done0 = n_done;
    push_exp(k);
    key = k;
    start = 1'b1;
    rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    step();
    lat = -1;
    tot = -1;
    for (int n = 1; n <= 400; n++) begin
      if (rk_valid === 1'b1 && lat < 0) lat = n;
      if (done === 1'b1) begin
        tot = n;
        break;
      end
      start = hold_start;
      if (hold_start) key = {$urandom, $urandom};
      rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    chk("run_completed", 64'(tot > 0), 64'd1);
    // start is still high in the done cycle when hold_start is set
    start = 1'b0;
    rk_ready = 1'b0;
    step();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_valid", 64'(rk_valid), 64'd0);
    chk("accepted_count", 64'(n_acc - acc0), 64'(NR + 1));
    chk("done_count", 64'(n_done - done0), 64'd1);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("run key=%h rnd_ready=%0d hold_start=%0d latency=%0d done_at=%0d", k, rnd_ready, hold_start, lat, tot);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, tot, d0;
    logic [63:0] rk;
    rst_n = 1'b1;
    start = 1'b0;
    key = '0;
    rk_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_valid", 64'(rk_valid), 64'd0);
    chk("reset_key", round_key, 64'd0);
    chk("reset_idx", 64'(round_idx), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Test 1: zero key, always ready
    run(64'h0, 1'b0, 1'b0, lat, tot);
    chk("t1_latency", 64'(lat), 64'(NR + 1));
    chk("t1_back_to_back", 64'(tot - lat), 64'(NR + 1));
    chk("t1_key2", got[2], 64'h0000010000777700);
    chk("t1_key1", got[1], 64'h0);

    // Test 2: zero key, random backpressure
    run(64'h0, 1'b1, 1'b0, lat, tot);

    // Test 6: issued keys decrypt the reference vector
    chk("t6_decrypt", decrypt(64'hCDC0B51F14722BBE), 64'hFFFFFFFFFFFFFFFF);

    // Test 3: start and key hammered during the whole sequence
    run(64'h0123456789ABCDEF, 1'b1, 1'b1, lat, tot);
    chk("t3_latency", 64'(lat), 64'(NR + 1));

    // Test 4: asynchronous reset mid-ISSUE at idx 7
    push_exp(64'h0);
    key = 64'h0;
    start = 1'b1;
    rk_ready = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (rk_valid === 1'b1 && round_idx == IDX_W'(7)) break;
      step();
    end
    chk("t4_reached_idx7", 64'(round_idx), 64'd7);
    d0 = n_done;
    rst_n = 1'b0;
    #1;
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_valid", 64'(rk_valid), 64'd0);
    chk("t4_key", round_key, 64'd0);
    chk("t4_idx", 64'(round_idx), 64'd0);
    chk("t4_done", 64'(done), 64'd0);
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    chk("t4_no_done", 64'(n_done - d0), 64'd0);
    chk("t4_stays_idle", 64'(busy), 64'd0);
    run(64'h0, 1'b0, 1'b0, lat, tot);
    chk("t4_restart_latency", 64'(lat), 64'(NR + 1));

    // Test 5: random keys against the schedule model
    for (int t = 0; t < 4; t++) begin
      rk = {$urandom, $urandom};
      run(rk, (t % 2) == 1, 1'b0, lat, tot);
      chk("t5_latency", 64'(lat), 64'(NR + 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
